parking_registry: RTL and testbench

PARKING_REGISTRY -- requirements
Module: parking_registry

---
 rtl/parking_pkg.sv | 47 ++++
 rtl/parking_id_decode.sv | 49 ++++
 rtl/parking_registry.sv | 216 +++++++++++++++++++++
 tb/tb_parking_registry.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared encodings for the parking registry: opcodes, result codes,
// ID classes, controller states and the commit actions chosen in LOOKUP.
package parking_pkg;

    localparam logic [2:0] OP_ENTER      = 3'd0;
    localparam logic [2:0] OP_EXIT       = 3'd1;
    localparam logic [2:0] OP_RESTRICT   = 3'd2;
    localparam logic [2:0] OP_UNRESTRICT = 3'd3;
    localparam logic [2:0] OP_QUERY      = 3'd4;

    typedef enum logic [3:0] {
        ST_OK         = 4'd0,
        ST_OK_ALT     = 4'd1,
        ST_UNKNOWN    = 4'd2,
        ST_RESTRICTED = 4'd3,
        ST_ALREADY_IN = 4'd4,
        ST_NOT_IN     = 4'd5,
        ST_FULL       = 4'd6,
        ST_NOT_ADMIN  = 4'd7,
        ST_BAD_OP     = 4'd8,
        ST_BAD_FLOOR  = 4'd9
    } status_e;

    typedef enum logic [1:0] {
        CLS_UNKNOWN = 2'd0,
        CLS_USER    = 2'd1,
        CLS_SPECIAL = 2'd2,
        CLS_ADMIN   = 2'd3
    } id_class_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } fsm_e;

    typedef enum logic [2:0] {
        ACT_NONE       = 3'd0,
        ACT_ENTER_U    = 3'd1,
        ACT_EXIT_U     = 3'd2,
        ACT_ENTER_S    = 3'd3,
        ACT_EXIT_S     = 3'd4,
        ACT_RESTRICT   = 3'd5,
        ACT_UNRESTRICT = 3'd6
    } act_e;

endpackage

// File: rtl/parking_id_decode.sv
// Combinational ID classifier: prefix match plus postfix range per class.
// An ID falling into zero or several class ranges is reported as unknown.
module parking_id_decode
    import parking_pkg::*;
#(
    parameter int          N_USERS    = 12,
    parameter int          N_SPECIAL  = 2,
    parameter int          N_ADMIN    = 2,
    parameter logic [19:0] ID_PREFIX  = 20'h20230,
    parameter logic [7:0]  USER_BASE  = 8'h10,
    parameter logic [7:0]  SPEC_BASE  = 8'h00,
    parameter logic [7:0]  ADMIN_BASE = 8'h02,
    parameter int          IW         = 4
) (
    input  logic [27:0]   id_i,
    output id_class_e     cls_o,
    output logic [IW-1:0] idx_o
);

    // Nine-bit bounds so a range ending at 8'hFF does not wrap.
    localparam logic [8:0] U_LO = {1'b0, USER_BASE};
    localparam logic [8:0] U_HI = U_LO + 9'(N_USERS);
    localparam logic [8:0] S_LO = {1'b0, SPEC_BASE};
    localparam logic [8:0] S_HI = S_LO + 9'(N_SPECIAL);
    localparam logic [8:0] A_LO = {1'b0, ADMIN_BASE};
    localparam logic [8:0] A_HI = A_LO + 9'(N_ADMIN);

    logic       pfx_ok;
    logic [8:0] pf;
    logic       in_u, in_s, in_a;

    assign pfx_ok = (id_i[27:8] == ID_PREFIX);
    assign pf     = {1'b0, id_i[7:0]};
    assign in_u   = pfx_ok && (pf >= U_LO) && (pf < U_HI);
    assign in_s   = pfx_ok && (pf >= S_LO) && (pf < S_HI);
    assign in_a   = pfx_ok && (pf >= A_LO) && (pf < A_HI);

    always_comb begin
        cls_o = CLS_UNKNOWN;
        idx_o = '0;
        case ({in_u, in_s, in_a})
            3'b100: begin cls_o = CLS_USER;    idx_o = IW'(pf - U_LO); end
            3'b010: begin cls_o = CLS_SPECIAL; idx_o = IW'(pf - S_LO); end
            3'b001: begin cls_o = CLS_ADMIN;   idx_o = IW'(pf - A_LO); end
            default: ;
        endcase
    end

endmodule

// File: rtl/parking_registry.sv
// Parking registry controller: IDLE accepts, LOOKUP decides and commits,
// RESP holds the result until consumed.
module parking_registry
    import parking_pkg::*;
#(
    parameter int          N_USERS    = 12,
    parameter int          N_SPECIAL  = 2,
    parameter int          N_ADMIN    = 2,
    parameter int          N_FLOORS   = 2,
    parameter int          FLR_CAP    = 4,
    parameter int          SPEC_CAP   = 2,
    parameter logic [19:0] ID_PREFIX  = 20'h20230,
    parameter logic [7:0]  USER_BASE  = 8'h10,
    parameter logic [7:0]  SPEC_BASE  = 8'h00,
    parameter logic [7:0]  ADMIN_BASE = 8'h02,
    localparam int FW   = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1,
    localparam int CW   = $clog2(FLR_CAP + 1),
    localparam int SW   = $clog2(SPEC_CAP + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [27:0]            req_id,
    input  logic [27:0]            req_admin_id,
    input  logic [FW-1:0]          req_floor,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_status,
    output logic [FW-1:0]          rsp_floor,
    output logic [N_FLOORS*CW-1:0] free_cnt,
    output logic [SW-1:0]          spec_free
);

    localparam int MAXN = (N_USERS > N_SPECIAL) ? ((N_USERS > N_ADMIN) ? N_USERS : N_ADMIN)
                                                : ((N_SPECIAL > N_ADMIN) ? N_SPECIAL : N_ADMIN);
    localparam int IW = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [N_USERS-1:0]   ONE_U = 1;
    localparam logic [N_SPECIAL-1:0] ONE_S = 1;

    fsm_e                    state_q;
    logic [2:0]              op_q;
    logic [27:0]             id_q, adm_q;
    logic [FW-1:0]           floor_q;
    logic                    rsp_valid_q;
    status_e                 rsp_status_q;
    logic [FW-1:0]           rsp_floor_q;
    logic [N_USERS-1:0]      inside_u_q, restr_q;
    logic [N_USERS*FW-1:0]   ufloor_q;
    logic [N_SPECIAL-1:0]    inside_s_q;
    logic [CW-1:0]           free_q [N_FLOORS];
    logic [SW-1:0]           spec_free_q;

    // Slot 0 classifies the subject, slot 1 the admin credential.
    logic [27:0]   dec_id  [2];
    id_class_e     dec_cls [2];
    logic [IW-1:0] dec_idx [2];

    assign dec_id[0] = id_q;
    assign dec_id[1] = adm_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            parking_id_decode #(
                .N_USERS(N_USERS), .N_SPECIAL(N_SPECIAL), .N_ADMIN(N_ADMIN),
                .ID_PREFIX(ID_PREFIX), .USER_BASE(USER_BASE),
                .SPEC_BASE(SPEC_BASE), .ADMIN_BASE(ADMIN_BASE), .IW(IW)
            ) u_dec (
                .id_i  (dec_id[gi]),
                .cls_o (dec_cls[gi]),
                .idx_o (dec_idx[gi])
            );
        end
        for (gi = 0; gi < N_FLOORS; gi++) begin : g_free
            assign free_cnt[gi*CW +: CW] = free_q[gi];
        end
    endgenerate

    logic          user_in, spec_in, restricted, any_free;
    logic [FW-1:0] rec_fl, first_free, fl_d;
    status_e       st_d;
    act_e          act_d;

    always_comb begin
        user_in    = |(inside_u_q & (ONE_U << dec_idx[0]));
        restricted = |(restr_q & (ONE_U << dec_idx[0]));
        spec_in    = |(inside_s_q & (ONE_S << dec_idx[0]));
        rec_fl     = ufloor_q[dec_idx[0]*FW +: FW];
        any_free   = 1'b0;
        first_free = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (free_q[i] != '0) begin
                any_free   = 1'b1;
                first_free = FW'(i);
            end
        end
        st_d  = ST_OK;
        fl_d  = '0;
        act_d = ACT_NONE;
        case (op_q)
            OP_ENTER: begin
                if (dec_cls[0] == CLS_USER) begin
                    if (restricted)                     st_d = ST_RESTRICTED;
                    else if (user_in)                   st_d = ST_ALREADY_IN;
                    else if (int'(floor_q) >= N_FLOORS) st_d = ST_BAD_FLOOR;
                    else if (free_q[floor_q] != '0) begin
                        fl_d  = floor_q;
                        act_d = ACT_ENTER_U;
                    end else if (any_free) begin
                        st_d  = ST_OK_ALT;
                        fl_d  = first_free;
                        act_d = ACT_ENTER_U;
                    end else                            st_d = ST_FULL;
                end else if (dec_cls[0] == CLS_SPECIAL) begin
                    if (spec_in)                  st_d = ST_ALREADY_IN;
                    else if (spec_free_q != '0)   act_d = ACT_ENTER_S;
                    else                          st_d = ST_FULL;
                end else                          st_d = ST_UNKNOWN;
            end
            OP_EXIT: begin
                if (dec_cls[0] == CLS_USER) begin
                    if (!user_in) st_d = ST_NOT_IN;
                    else begin fl_d = rec_fl; act_d = ACT_EXIT_U; end
                end else if (dec_cls[0] == CLS_SPECIAL) begin
                    if (!spec_in) st_d = ST_NOT_IN;
                    else          act_d = ACT_EXIT_S;
                end else          st_d = ST_UNKNOWN;
            end
            OP_RESTRICT, OP_UNRESTRICT: begin
                if (dec_cls[1] != CLS_ADMIN)     st_d = ST_NOT_ADMIN;
                else if (dec_cls[0] != CLS_USER) st_d = ST_UNKNOWN;
                else act_d = (op_q == OP_RESTRICT) ? ACT_RESTRICT : ACT_UNRESTRICT;
            end
            OP_QUERY: begin
                if (dec_cls[0] == CLS_USER) begin
                    if (user_in) fl_d = rec_fl;
                    else         st_d = ST_NOT_IN;
                end else if (dec_cls[0] == CLS_SPECIAL) begin
                    if (!spec_in) st_d = ST_NOT_IN;
                end else          st_d = ST_UNKNOWN;
            end
            default: st_d = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            id_q         <= '0;
            adm_q        <= '0;
            floor_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_floor_q  <= '0;
            inside_u_q   <= '0;
            restr_q      <= '0;
            ufloor_q     <= '0;
            inside_s_q   <= '0;
            spec_free_q  <= SW'(SPEC_CAP);
            for (int f = 0; f < N_FLOORS; f++) free_q[f] <= CW'(FLR_CAP);
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    id_q    <= req_id;
                    adm_q   <= req_admin_id;
                    floor_q <= req_floor;
                    state_q <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    rsp_status_q <= st_d;
                    rsp_floor_q  <= fl_d;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                    case (act_d)
                        ACT_ENTER_U: begin
                            inside_u_q <= inside_u_q | (ONE_U << dec_idx[0]);
                            ufloor_q[dec_idx[0]*FW +: FW] <= fl_d;
                            free_q[fl_d] <= free_q[fl_d] - CW'(1);
                        end
                        ACT_EXIT_U: begin
                            inside_u_q   <= inside_u_q & ~(ONE_U << dec_idx[0]);
                            free_q[fl_d] <= free_q[fl_d] + CW'(1);
                        end
                        ACT_ENTER_S: begin
                            inside_s_q  <= inside_s_q | (ONE_S << dec_idx[0]);
                            spec_free_q <= spec_free_q - SW'(1);
                        end
                        ACT_EXIT_S: begin
                            inside_s_q  <= inside_s_q & ~(ONE_S << dec_idx[0]);
                            spec_free_q <= spec_free_q + SW'(1);
                        end
                        ACT_RESTRICT:   restr_q <= restr_q | (ONE_U << dec_idx[0]);
                        ACT_UNRESTRICT: restr_q <= restr_q & ~(ONE_U << dec_idx[0]);
                        default: ;
                    endcase
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_floor  = rsp_floor_q;
    assign spec_free  = spec_free_q;

endmodule

// File: tb/tb_parking_registry.sv
// Directed plus random transactions against a behavioural model of the
// registry: occupancy is recounted from per-ID inside flags after each step.
module tb_parking_registry;

    localparam int NU = 12, NS = 2, NF = 2, CAP = 4, SCAP = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op;
    logic [27:0] req_id, req_admin_id;
    logic [0:0]  req_floor, rsp_floor;
    logic [3:0]  rsp_status;
    logic [5:0]  free_cnt;
    logic [1:0]  spec_free;

    int total = 0;
    int bad   = 0;

    // Reference state: who is inside, on which floor, who is restricted.
    int m_in_u [NU];
    int m_fl_u [NU];
    int m_rs_u [NU];
    int m_in_s [NS];

    parking_registry dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_id(req_id), .req_admin_id(req_admin_id),
        .req_floor(req_floor), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_floor(rsp_floor),
        .free_cnt(free_cnt), .spec_free(spec_free)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NU; i++) begin m_in_u[i] = 0; m_fl_u[i] = 0; m_rs_u[i] = 0; end
        for (int i = 0; i < NS; i++) m_in_s[i] = 0;
    endfunction

    // 0 unknown, 1 user, 2 special, 3 admin
    function automatic void classify(input logic [27:0] id, output int cls, output int idx);
        int pf;
        pf  = int'(id[7:0]);
        cls = 0;
        idx = 0;
        if (id[27:8] == 20'h20230) begin
            if (pf >= 16 && pf < 16 + NU) begin cls = 1; idx = pf - 16; end
            else if (pf < NS)             begin cls = 2; idx = pf; end
            else if (pf >= 2 && pf < 4)   begin cls = 3; idx = pf - 2; end
        end
    endfunction

    function automatic int floor_free(input int f);
        int occ = 0;
        for (int i = 0; i < NU; i++) if (m_in_u[i] != 0 && m_fl_u[i] == f) occ++;
        return CAP - occ;
    endfunction

    function automatic int spec_left();
        int occ = 0;
        for (int i = 0; i < NS; i++) if (m_in_s[i] != 0) occ++;
        return SCAP - occ;
    endfunction

    function automatic logic [5:0] free_vec();
        logic [5:0] v;
        for (int f = 0; f < NF; f++) v[f*3 +: 3] = 3'(floor_free(f));
        return v;
    endfunction

    function automatic void model(input int op, input logic [27:0] id, input logic [27:0] adm,
                                  input int fl, output int st, output int rf);
        int c, i, ac, ai, pick;
        classify(id, c, i);
        classify(adm, ac, ai);
        st = 0;
        rf = 0;
        case (op)
            0: if (c == 1) begin
                   if (m_rs_u[i] != 0)      st = 3;
                   else if (m_in_u[i] != 0) st = 4;
                   else if (fl >= NF)       st = 9;
                   else begin
                       pick = -1;
                       if (floor_free(fl) > 0) pick = fl;
                       else begin
                           for (int f = NF - 1; f >= 0; f--) if (floor_free(f) > 0) pick = f;
                           st = 1;
                       end
                       if (pick < 0) st = 6;
                       else begin m_in_u[i] = 1; m_fl_u[i] = pick; rf = pick; end
                   end
               end else if (c == 2) begin
                   if (m_in_s[i] != 0)     st = 4;
                   else if (spec_left() > 0) m_in_s[i] = 1;
                   else                    st = 6;
               end else st = 2;
            1: if (c == 1) begin
                   if (m_in_u[i] == 0) st = 5;
                   else begin m_in_u[i] = 0; rf = m_fl_u[i]; end
               end else if (c == 2) begin
                   if (m_in_s[i] == 0) st = 5;
                   else m_in_s[i] = 0;
               end else st = 2;
            2, 3: if (ac != 3)      st = 7;
                  else if (c != 1)  st = 2;
                  else m_rs_u[i] = (op == 2) ? 1 : 0;
            4: if (c == 1) begin
                   if (m_in_u[i] != 0) rf = m_fl_u[i];
                   else st = 5;
               end else if (c == 2) begin
                   if (m_in_s[i] == 0) st = 5;
               end else st = 2;
            default: st = 8;
        endcase
    endfunction

    // One full handshake; want >= 0 additionally pins the status to a constant.
    task automatic txn(input int op, input logic [27:0] id, input logic [27:0] adm,
                       input int fl, input int hold, input int want);
        int est, erf;
        @(negedge CLK);
        req_op = 3'(op); req_id = id; req_admin_id = adm; req_floor = 1'(fl);
        req_valid = 1'b1;
        check("ready_in_idle", req_ready, 1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        model(op, id, adm, fl, est, erf);
        check("no_rsp_in_lookup", rsp_valid, 0);
        check("busy_in_lookup", req_ready, 0);
        @(posedge CLK); #1;
        check("rsp_valid_lat2", rsp_valid, 1);
        check("status", rsp_status, est);
        check("floor", rsp_floor, erf);
        check("free_cnt", free_cnt, free_vec());
        check("spec_free", spec_free, spec_left());
        if (want >= 0) check("status_directed", rsp_status, want);
        for (int k = 0; k < hold; k++) begin
            @(posedge CLK); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_ready_low", req_ready, 0);
            check("hold_status", rsp_status, est);
            check("hold_floor", rsp_floor, erf);
        end
        $display("txn op=%0d id=%07h adm=%07h fl=%0d -> status=%0d floor=%0d free=%02h spec=%0d",
                 op, id, adm, fl, rsp_status, rsp_floor, free_cnt, spec_free);
        @(negedge CLK) rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("ready_again", req_ready, 1);
    endtask

    function automatic logic [27:0] rand_id();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return {20'h20230, 8'(8'h10 + $urandom_range(0, NU - 1))};
        if (r <= 7) return {20'h20230, 8'($urandom_range(0, NS - 1))};
        if (r == 8) return {20'h20230, 8'($urandom_range(2, 3))};
        return ($urandom_range(0, 1) == 0) ? 28'h2023050 : 28'h2024011;
    endfunction

    initial begin
        int op, r;
        model_reset();
        RST = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_id = '0; req_admin_id = '0; req_floor = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_status", rsp_status, 0);
        check("rst_floor", rsp_floor, 0);
        check("rst_free_cnt", free_cnt, 6'b100_100);
        check("rst_spec_free", spec_free, 2);
        @(negedge CLK) RST = 1'b0;
        #1 check("rst_ready", req_ready, 1);

        txn(0, 28'h2023010, 28'h0, 1, 0, 0);
        check("first_enter_f1_free", free_cnt[5:3], 3);
        txn(0, 28'h2023011, 28'h0, 1, 0, 0);
        txn(0, 28'h2023012, 28'h0, 1, 0, 0);
        txn(0, 28'h2023013, 28'h0, 1, 0, 0);
        txn(0, 28'h2023014, 28'h0, 1, 0, 1);
        txn(0, 28'h2023015, 28'h0, 0, 0, 0);
        txn(0, 28'h2023016, 28'h0, 0, 0, 0);
        txn(0, 28'h2023017, 28'h0, 0, 0, 0);
        txn(0, 28'h2023018, 28'h0, 0, 0, 6);
        check("full_counters", free_cnt, 6'b000_000);

        txn(2, 28'h2023012, 28'h2023003, 0, 0, 0);
        txn(0, 28'h2023012, 28'h0, 1, 0, 3);
        txn(2, 28'h2023013, 28'h2023011, 0, 0, 7);
        txn(2, 28'h2023012, 28'h2023003, 0, 0, 0);
        txn(1, 28'h2023012, 28'h0, 0, 0, 0);
        txn(3, 28'h2023012, 28'h2023002, 0, 0, 0);
        txn(2, 28'h2023000, 28'h2023002, 0, 0, 2);

        txn(0, 28'h2023000, 28'h0, 1, 0, 0);
        txn(0, 28'h2023001, 28'h0, 1, 0, 0);
        check("spec_exhausted", spec_free, 0);
        txn(0, 28'h2023000, 28'h0, 0, 0, 4);
        txn(1, 28'h2023001, 28'h0, 0, 0, 0);
        txn(0, 28'h2023001, 28'h0, 0, 0, 0);

        txn(4, 28'h2023010, 28'h0, 0, 5, 0);
        txn(1, 28'h2023019, 28'h0, 0, 0, 5);
        txn(6, 28'h2023010, 28'h0, 0, 0, 8);
        txn(0, 28'h2023002, 28'h0, 0, 0, 2);
        txn(4, 28'h2023050, 28'h0, 0, 0, 2);
        txn(0, 28'h2024010, 28'h0, 0, 0, 2);
        txn(4, 28'h2023014, 28'h0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      op = 0;
            else if (r <= 4) op = 1;
            else if (r == 5) op = 2;
            else if (r == 6) op = 3;
            else if (r <= 8) op = 4;
            else             op = $urandom_range(5, 7);
            txn(op, rand_id(),
                ($urandom_range(0, 3) != 0) ? {20'h20230, 8'($urandom_range(2, 3))} : rand_id(),
                $urandom_range(0, 1), 0, -1);
        end

        // Reset lands while an ENTER sits in LOOKUP.
        @(negedge CLK);
        req_op = 3'd0; req_id = 28'h2023015; req_admin_id = '0; req_floor = 1'b0;
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("lookup_before_rst", rsp_valid, 0);
        #1 RST = 1'b1;
        #1;
        check("rst_mid_free", free_cnt, 6'b100_100);
        check("rst_mid_spec", spec_free, 2);
        check("rst_mid_valid", rsp_valid, 0);
        @(negedge CLK) RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        check("rst_no_late_rsp", rsp_valid, 0);
        check("rst_free_after", free_cnt, 6'b100_100);
        txn(4, 28'h2023015, 28'h0, 0, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
